// File: rtl/dm_responder.sv
// dm_responder
//   Data-memory responder for the M-stage load/store port. One request is
//   accepted at a time through a valid/ready handshake. The response appears
//   a fixed LATENCY cycles after the accept edge and is held until it is
//   consumed. Word, half and byte stores are merged into a word array. Loads
//   return the full aligned word, read before any store to that word.
//   Misaligned accesses are flagged, return 0 and do not write the array.
//
// Parameters
//   ADDR_WIDTH  word-address bits; array depth is 2**ADDR_WIDTH words
//   LATENCY     cycles from the accept edge to resp_valid being seen (>= 1)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; also clears the array
//   req_valid   request present
//   req_ready   high only in IDLE and only while reset is released
//   req_we      1 = store, 0 = load
//   req_addr    byte address; bits above ADDR_WIDTH+1 are ignored
//   req_wdata   store data, right-justified for half and byte stores
//   req_size    00 word, 01 half, 10 byte, 11 word
//   req_pc      instruction PC; used only by the store log
//   resp_valid  response present; held until resp_ready is seen
//   resp_ready  consumer takes the response
//   resp_rdata  aligned word before the store; 0 on error
//   resp_err    misaligned access; qualified by resp_valid
module dm_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned WAIT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam int unsigned CW        = (WAIT_LOAD > 1) ? $clog2(WAIT_LOAD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] cnt;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;
  logic [31:0] cap_pc;

  logic [31:0] mem [DEPTH];

  // Commit-side view of the request. With LATENCY=1 the commit happens on the
  // accept edge itself, so the live request is used while still in IDLE;
  // otherwise the captured copy is used.
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_size;
  logic [31:0] c_pc;

  logic [ADDR_WIDTH-1:0] widx;
  logic                  mis;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  enter_resp;
  logic                  do_write;

  assign req_ready  = (state == IDLE) && reset;
  assign resp_valid = (state == RESP);

  always_comb begin
    if (state == IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_size  = req_size;
      c_pc    = req_pc;
    end else begin
      c_we    = cap_we;
      c_addr  = cap_addr;
      c_wdata = cap_wdata;
      c_size  = cap_size;
      c_pc    = cap_pc;
    end
  end

  assign widx     = c_addr[ADDR_WIDTH+1:2];
  assign old_word = mem[widx];

  always_comb begin
    case (c_size)
      2'b01:   mis = c_addr[0];
      2'b10:   mis = 1'b0;
      default: mis = |c_addr[1:0];
    endcase
  end

  always_comb begin
    merged = old_word;
    case (c_size)
      2'b01: begin
        if (c_addr[1]) merged[31:16] = c_wdata[15:0];
        else           merged[15:0]  = c_wdata[15:0];
      end
      2'b10:   merged[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
      default: merged = c_wdata;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) begin
            state_nxt = WAIT;
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign do_write = enter_resp && c_we && !mis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_size   <= '0;
      cap_pc     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_size  <= req_size;
        cap_pc    <= req_pc;
        cnt       <= CW'(WAIT_LOAD);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        resp_rdata <= mis ? '0 : old_word;
        resp_err   <= mis;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[widx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && do_write)
      $display("@%h: *%h <= %h", c_pc, {c_addr[31:2], 2'b00}, merged);
  end
`endif

endmodule
